// File: rtl/ita_hwpe_ctx_ctrl.sv
// ==== ita_hwpe_ctx_ctrl: job-context queue + engine sequencer (opt. ITA_HWPE_PERF_CNT_EN) ====
// ==== Revision 1.0 ====
`default_nettype none

module ita_hwpe_ctx_ctrl #(
  parameter int unsigned N_CONTEXT = 2,
  parameter int unsigned N_REGS    = 20,
  parameter int unsigned ID_WIDTH  = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      cfg_we_i,
  input  logic [$clog2(N_REGS)-1:0] cfg_addr_i,
  input  logic [31:0]               cfg_wdata_i,
  input  logic                      commit_i,
  input  logic                      done_i,
  output logic [N_REGS*32-1:0]      regs_o,
  output logic                      start_o,
  output logic [ID_WIDTH-1:0]       job_id_o,
  output logic                      evt_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic                      err_o,
  output logic [31:0]               perf_cnt_o
);

  localparam int unsigned PTR_W = $clog2(N_CONTEXT);
  localparam int unsigned CNT_W = $clog2(N_CONTEXT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_NEXT, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [31:0]         regs_q [N_CONTEXT][N_REGS];
  logic [31:0]         regs_d [N_CONTEXT][N_REGS];
  logic [ID_WIDTH-1:0] slot_id_q [N_CONTEXT];
  logic [ID_WIDTH-1:0] slot_id_d [N_CONTEXT];
  logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ID_WIDTH-1:0] id_cnt_q, id_cnt_d;
  logic                start_q, start_d, evt_q, evt_d, err_q, err_d;

  logic full, addr_ok, push, wr, pop;

  always_comb begin
    full    = (count_q == CNT_W'(N_CONTEXT));
    addr_ok = (32'(cfg_addr_i) < N_REGS);
    push    = commit_i && !full;
    wr      = cfg_we_i && !full && addr_ok;
    pop     = (state_q == S_RUN) && done_i;

    regs_d    = regs_q;
    slot_id_d = slot_id_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    id_cnt_d  = id_cnt_q;
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    err_d     = (cfg_we_i && (full || !addr_ok)) || (commit_i && full);
    start_d   = 1'b0;
    evt_d     = 1'b0;
    state_d   = state_q;

    if (wr) regs_d[wptr_q][cfg_addr_i] = cfg_wdata_i;
    if (push) begin
      slot_id_d[wptr_q] = id_cnt_q;
      wptr_d            = wptr_q + 1'b1;
      id_cnt_d          = id_cnt_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;

    case (state_q)
      S_IDLE: if (count_q != '0) begin
        state_d = S_RUN;
        start_d = 1'b1;
      end
      // A commit landing with the last done keeps the queue non-empty.
      S_RUN: if (pop) state_d = ((count_q > CNT_W'(1)) || push) ? S_NEXT : S_DONE;
      S_NEXT: begin
        state_d = S_RUN;
        start_d = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        evt_d   = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (clear_i) begin
      regs_d    = '{default: '0};
      slot_id_d = '{default: '0};
      wptr_d    = '0;
      rptr_d    = '0;
      count_d   = '0;
      id_cnt_d  = '0;
      start_d   = 1'b0;
      evt_d     = 1'b0;
      err_d     = 1'b0;
      state_d   = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_q    <= '{default: '0};
      slot_id_q <= '{default: '0};
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      id_cnt_q  <= '0;
      start_q   <= 1'b0;
      evt_q     <= 1'b0;
      err_q     <= 1'b0;
      state_q   <= S_IDLE;
    end else begin
      regs_q    <= regs_d;
      slot_id_q <= slot_id_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      id_cnt_q  <= id_cnt_d;
      start_q   <= start_d;
      evt_q     <= evt_d;
      err_q     <= err_d;
      state_q   <= state_d;
    end
  end

  always_comb begin
    regs_o = '0;
    for (int r = 0; r < int'(N_REGS); r++) regs_o[r*32 +: 32] = regs_q[rptr_q][r];
  end

  assign start_o  = start_q;
  assign evt_o    = evt_q;
  assign err_o    = err_q;
  assign job_id_o = slot_id_q[rptr_q];
  assign full_o   = full;
  assign empty_o  = (count_q == '0);

`ifdef ITA_HWPE_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q != S_IDLE && perf_q != 32'hFFFF_FFFF) perf_d = perf_q + 32'd1;
    if (clear_i) perf_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) perf_q <= '0;
    else         perf_q <= perf_d;
  end

  assign perf_cnt_o = perf_q;
`else
  assign perf_cnt_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ita_hwpe_ctx_ctrl.sv
// ==== tb_ita_hwpe_ctx_ctrl: directed vector bench for ita_hwpe_ctx_ctrl ====
// ==== Revision 1.0 ====
`default_nettype none

module tb_ita_hwpe_ctx_ctrl;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          we = 1'b0;
  logic [4:0]    addr = '0;
  logic [31:0]   wdata = '0;
  logic          commit = 1'b0;
  logic          done = 1'b0;
  logic [639:0]  regs;
  logic          start, evt, full, empty, err;
  logic [1:0]    jid;
  logic [31:0]   perf;

  int n_cmp = 0;
  int n_err = 0;

  ita_hwpe_ctx_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .cfg_we_i(we),
    .cfg_addr_i(addr), .cfg_wdata_i(wdata), .commit_i(commit), .done_i(done),
    .regs_o(regs), .start_o(start), .job_id_o(jid), .evt_o(evt),
    .full_o(full), .empty_o(empty), .err_o(err), .perf_cnt_o(perf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        commit;
    logic        done;
    logic        start, evt, err, full, empty;
    logic [1:0]  jid;
    logic [31:0] reg5;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic w, input logic [4:0] a, input logic [31:0] d,
                     input logic c, input logic dn, input logic st, input logic ev,
                     input logic er, input logic fu, input logic em,
                     input logic [1:0] j, input logic [31:0] r5);
    vec_t v;
    v = '{w, a, d, c, dn, st, ev, er, fu, em, j, r5};
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge.
  task automatic cyc(input logic w, input logic [4:0] a, input logic [31:0] d,
                     input logic c, input logic dn);
    we = w; addr = a; wdata = d; commit = c; done = dn;
    @(posedge clk);
    #1;
    we = 1'b0; commit = 1'b0; done = 1'b0;
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    // Single job, then three back-to-back commits into a 2-deep queue.
    add(1, 5,  32'h40, 0, 0,  0,0,0,0,1, 2'd0, 32'h40);
    add(0, 0,  0,      1, 0,  0,0,0,0,0, 2'd0, 32'h40);
    add(0, 0,  0,      0, 0,  1,0,0,0,0, 2'd0, 32'h40);
    add(0, 0,  0,      0, 0,  0,0,0,0,0, 2'd0, 32'h40);
    add(0, 0,  0,      0, 0,  0,0,0,0,0, 2'd0, 32'h40);
    add(0, 0,  0,      0, 0,  0,0,0,0,0, 2'd0, 32'h40);
    add(0, 0,  0,      0, 1,  0,0,0,0,1, 2'd0, 32'h0);
    add(0, 0,  0,      0, 0,  0,1,0,0,1, 2'd0, 32'h0);
    add(0, 0,  0,      0, 0,  0,0,0,0,1, 2'd0, 32'h0);
    add(0, 0,  0,      1, 0,  0,0,0,0,0, 2'd1, 32'h0);
    add(0, 0,  0,      1, 0,  1,0,0,1,0, 2'd1, 32'h0);
    add(0, 0,  0,      1, 0,  0,0,1,1,0, 2'd1, 32'h0);
    add(0, 0,  0,      0, 0,  0,0,0,1,0, 2'd1, 32'h0);
    add(0, 0,  0,      0, 1,  0,0,0,0,0, 2'd2, 32'h40);
    add(0, 0,  0,      0, 0,  1,0,0,0,0, 2'd2, 32'h40);
    add(0, 0,  0,      0, 1,  0,0,0,0,1, 2'd1, 32'h0);
    add(0, 0,  0,      0, 0,  0,1,0,0,1, 2'd1, 32'h0);
    add(0, 0,  0,      0, 0,  0,0,0,0,1, 2'd1, 32'h0);
    add(1, 25, 32'hFF, 0, 0,  0,0,1,0,1, 2'd1, 32'h0);
    add(0, 0,  0,      0, 0,  0,0,0,0,1, 2'd1, 32'h0);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_empty", empty, 1);
    chk("rst_full",  full,  0);
    chk("rst_start", start, 0);
    chk("rst_evt",   evt,   0);
    chk("rst_err",   err,   0);
    chk("rst_regs",  |regs, 0);
    chk("rst_perf",  perf,  0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].commit, tbl[i].done);
      chk($sformatf("row%0d_start", i), start, tbl[i].start);
      chk($sformatf("row%0d_evt", i),   evt,   tbl[i].evt);
      chk($sformatf("row%0d_err", i),   err,   tbl[i].err);
      chk($sformatf("row%0d_full", i),  full,  tbl[i].full);
      chk($sformatf("row%0d_empty", i), empty, tbl[i].empty);
      chk($sformatf("row%0d_jid", i),   jid,   tbl[i].jid);
      chk($sformatf("row%0d_reg5", i),  regs[5*32 +: 32], tbl[i].reg5);
    end

    // Commit coinciding with the final done: queue stays at one, next job starts.
    cyc(0, 0, 0, 1, 0);
    chk("cd_jid_a", jid, 2'd3);
    idle();
    chk("cd_start_a", start, 1);
    cyc(0, 0, 0, 1, 1);
    chk("cd_empty", empty, 0);
    chk("cd_full",  full,  0);
    chk("cd_start_none", start, 0);
    chk("cd_jid_wrap", jid, 2'd0);
    idle();
    chk("cd_start_b", start, 1);
    chk("cd_evt_none", evt, 0);
    cyc(0, 0, 0, 0, 1);
    chk("cd_empty_end", empty, 1);
    idle();
    chk("cd_evt", evt, 1);

    // Asynchronous reset in the middle of a two-job run.
    cyc(1, 3, 32'hDEAD, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("ar_start", start, 1);
    chk("ar_full", full, 1);
    idle();
    rst_n = 1'b0;
    #1;
    chk("ar_empty", empty, 1);
    chk("ar_full0", full, 0);
    chk("ar_regs",  |regs, 0);
    chk("ar_jid",   jid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle();
      chk($sformatf("ar_post%0d_evt", i), evt, 0);
      chk($sformatf("ar_post%0d_start", i), start, 0);
    end

    // Busy-cycle counter over one job held for twelve Run cycles.
    cyc(0, 0, 0, 1, 0);
    idle();
    repeat (12) idle();
    cyc(0, 0, 0, 0, 1);
    idle();
    chk("perf_evt", evt, 1);
`ifdef ITA_HWPE_PERF_CNT_EN
    chk("perf_cnt", perf, 32'd14);
`else
    chk("perf_cnt", perf, 32'd0);
`endif

    // Synchronous clear during Run.
    cyc(1, 7, 32'h1234, 0, 0);
    chk("cl_reg7", regs[7*32 +: 32], 32'h1234);
    cyc(0, 0, 0, 1, 0);
    idle();
    chk("cl_start", start, 1);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    chk("cl_empty", empty, 1);
    chk("cl_regs",  |regs, 0);
    chk("cl_perf",  perf, 0);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk($sformatf("cl_post%0d_evt", i), evt, 0);
      chk($sformatf("cl_post%0d_start", i), start, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
